mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage RISC-V core.
- Turns MemRead/MemWrite into a request/acknowledge transaction on a multi-cycle data-memory port.
- Stalls the upstream pipeline until the transaction completes.
- Contains the MEM/WB pipeline register, feeding writeback with ALU result or load data.

Parameters:
TIMEOUT_CYC, 255, BUSY cycles without mem_ack_i before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
RegWrite_i  in  1  from EX/MEM
MemtoReg_i  in  1  from EX/MEM
MemRead_i  in  1  from EX/MEM, load
MemWrite_i  in  1  from EX/MEM, store
ALUResult_i  in  32  from EX/MEM, ALU result / memory address
RS2data_i  in  32  from EX/MEM, store data
RDaddr_i  in  5  from EX/MEM, destination register
mem_req_o  out  1  memory request, level, held until ack
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  32  memory address
mem_wdata_o  out  32  write data
mem_ack_i  in  1  memory acknowledge, single-cycle pulse
mem_rdata_i  in  32  read data, valid while mem_ack_i=1
stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
RegWrite_o  out  1  MEM/WB register
MemtoReg_o  out  1  MEM/WB register
ALUResult_o  out  32  MEM/WB register
MemData_o  out  32  MEM/WB register, load data
RDaddr_o  out  5  MEM/WB register
err_o  out  1  sticky timeout flag

Behaviour:
Reset:
- While rst_i=0, asynchronously: state=IDLE, counter=0.
- All registered outputs are 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, all MEM/WB outputs, err_o.
- stall_o evaluates to 0 in IDLE with no memory op.

Memory operation:
- mem_op = MemRead_i | MemWrite_i.
- If both are set, the op is treated as a write: mem_we_o=1, and the MEM/WB load uses MemData_o=0.

States:
- IDLE, no mem_op: MEM/WB loads the EX/MEM inputs at each clock edge, with MemData_o=0. Latency 1 cycle, stall_o=0.
- IDLE, mem_op: stall_o=1 combinationally. At the edge:
  - latch mem_addr_o=ALUResult_i, mem_wdata_o=RS2data_i, mem_we_o;
  - set mem_req_o=1, clear the counter, go to BUSY;
  - MEM/WB loads a bubble: all MEM/WB outputs 0.
- BUSY: stall_o=1, and MEM/WB loads a bubble each edge.
  - mem_req_o, mem_addr_o, mem_wdata_o and mem_we_o stay stable.
  - Counter increments each cycle.
  - On mem_ack_i=1: capture mem_rdata_i (reads only; writes capture 0), drop mem_req_o, go to DONE.
  - If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 with no ack: set err_o, drop mem_req_o, captured data=0, go to DONE.
  - Ack and timeout in the same cycle: the ack wins and err_o is not set.
- DONE: stall_o=0. EX/MEM still holds the same instruction, so it is not re-issued.
  - At the edge, MEM/WB loads RegWrite_i, MemtoReg_i, ALUResult_i, RDaddr_i and MemData_o=captured data.
  - Go to IDLE.

Timing and signal rules:
- Minimum stall for a memory op is 2 cycles, when the ack arrives in the first BUSY cycle.
- In general, stall cycles = 1 + number of BUSY cycles.
- mem_req_o is low in DONE and IDLE, so back-to-back memory ops leave a 2-cycle gap between requests.
- mem_ack_i outside BUSY is ignored, including a stale ack after reset or after a timeout.
- err_o is cleared only by reset.
- Reset in BUSY drops mem_req_o immediately. Resolving the memory side of the abort is the memory's responsibility; this block ignores any later ack.
- All outputs except stall_o are registered. stall_o = (IDLE & mem_op) | BUSY.

Test Plan:
1. Non-memory op: RegWrite=1, ALUResult=0x10, RD=5.
   -> Next edge: RegWrite_o=1, ALUResult_o=0x10, RDaddr_o=5, MemData_o=0. stall_o and mem_req_o stay 0.
2. Load: addr 0x100, RD=7, MemtoReg=1, ack on the 3rd BUSY cycle with rdata 0xDEADBEEF.
   -> mem_req_o high 3 cycles, mem_we_o=0, stall_o high 4 cycles, bubbles in MEM/WB.
   -> Then RegWrite_o=1, MemData_o=0xDEADBEEF, RDaddr_o=7.
3. Store: addr 0x200, data 0xCAFEF00D, ack in the first BUSY cycle.
   -> mem_we_o=1, mem_wdata_o=0xCAFEF00D, stall_o high exactly 2 cycles, RegWrite_o=0.
4. TIMEOUT_CYC=4, load with no ack.
   -> mem_req_o drops after 4 BUSY cycles, err_o=1 and stays set, stall_o released, MemData_o=0.
   -> Ack pulse 2 cycles later has no effect.
5. rst_i low during BUSY.
   -> mem_req_o, stall_o and all outputs go 0 without waiting for a clock edge.
   -> After release, a stray ack is ignored. A following load to 0x300 with ack returns correct data.
6. Load then store back-to-back; also the MemRead=MemWrite=1 case.
   -> Two independent transactions, mem_req_o low for ≥2 cycles between requests, each completes correctly.
   -> The dual-flag op issues a write and yields MemData_o=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives a req/ack data-memory port for loads and stores,
// stalls the upstream pipeline while a transaction is outstanding, and holds MEM/WB.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit              TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      rdata_cap, rdata_cap_next;
  logic             req_next, we_next, err_next;
  logic [31:0]      addr_next, wdata_next;
  logic             wb_rw_next, wb_mtr_next;
  logic [31:0]      wb_alu_next, wb_mdata_next;
  logic [4:0]       wb_rd_next;
  logic             mem_op;

  assign mem_op = MemRead_i | MemWrite_i;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    rdata_cap_next = rdata_cap;
    req_next       = mem_req_o;
    we_next        = mem_we_o;
    addr_next      = mem_addr_o;
    wdata_next     = mem_wdata_o;
    err_next       = err_o;
    stall_o        = 1'b0;
    wb_rw_next     = 1'b0;
    wb_mtr_next    = 1'b0;
    wb_alu_next    = 32'h0;
    wb_mdata_next  = 32'h0;
    wb_rd_next     = 5'h0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_o    = 1'b1;
          addr_next  = ALUResult_i;
          wdata_next = RS2data_i;
          we_next    = MemWrite_i;
          req_next   = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end else begin
          wb_rw_next  = RegWrite_i;
          wb_mtr_next = MemtoReg_i;
          wb_alu_next = ALUResult_i;
          wb_rd_next  = RDaddr_i;
        end
      end
      BUSY: begin
        stall_o  = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack_i) begin
          rdata_cap_next = mem_we_o ? 32'h0 : mem_rdata_i;
          req_next       = 1'b0;
          state_next     = DONE;
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          rdata_cap_next = 32'h0;
          err_next       = 1'b1;
          req_next       = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        wb_rw_next    = RegWrite_i;
        wb_mtr_next   = MemtoReg_i;
        wb_alu_next   = ALUResult_i;
        wb_rd_next    = RDaddr_i;
        wb_mdata_next = rdata_cap;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata_cap   <= 32'h0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      err_o       <= 1'b0;
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ALUResult_o <= 32'h0;
      MemData_o   <= 32'h0;
      RDaddr_o    <= 5'h0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rdata_cap   <= rdata_cap_next;
      mem_req_o   <= req_next;
      mem_we_o    <= we_next;
      mem_addr_o  <= addr_next;
      mem_wdata_o <= wdata_next;
      err_o       <= err_next;
      RegWrite_o  <= wb_rw_next;
      MemtoReg_o  <= wb_mtr_next;
      ALUResult_o <= wb_alu_next;
      MemData_o   <= wb_mdata_next;
      RDaddr_o    <= wb_rd_next;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a transaction-level reference model checked every cycle,
// plus literal expectations for stall lengths, request counts and writeback data.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk_i, rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUResult_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ALUResult_o, MemData_o;
  logic [4:0]  RDaddr_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALUResult_o(ALUResult_o), .MemData_o(MemData_o), .RDaddr_o(RDaddr_o),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: one outstanding transaction, its age in memory-wait cycles,
  // and a finished result waiting to be written back.
  logic        m_active, m_ready, m_req, m_we, m_err;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_result;
  logic        m_rw, m_mtr;
  logic [31:0] m_alu, m_mdata;
  logic [4:0]  m_rd;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_active <= 0; m_ready <= 0; m_req <= 0; m_we <= 0; m_err <= 0; m_age <= 0;
      m_addr <= 0; m_wdata <= 0; m_result <= 0;
      m_rw <= 0; m_mtr <= 0; m_alu <= 0; m_mdata <= 0; m_rd <= 0;
    end else if (m_active) begin
      m_age <= m_age + 1;
      m_rw <= 0; m_mtr <= 0; m_alu <= 0; m_mdata <= 0; m_rd <= 0;
      if (mem_ack_i) begin
        m_result <= m_we ? 32'h0 : mem_rdata_i;
        m_req <= 0; m_active <= 0; m_ready <= 1;
      end else if (TO != 0 && m_age + 1 == TO) begin
        m_result <= 32'h0; m_err <= 1;
        m_req <= 0; m_active <= 0; m_ready <= 1;
      end
    end else if (m_ready) begin
      m_rw <= RegWrite_i; m_mtr <= MemtoReg_i; m_alu <= ALUResult_i; m_rd <= RDaddr_i;
      m_mdata <= m_result; m_ready <= 0;
    end else if (MemRead_i | MemWrite_i) begin
      m_addr <= ALUResult_i; m_wdata <= RS2data_i; m_we <= MemWrite_i;
      m_req <= 1; m_active <= 1; m_age <= 0;
      m_rw <= 0; m_mtr <= 0; m_alu <= 0; m_mdata <= 0; m_rd <= 0;
    end else begin
      m_rw <= RegWrite_i; m_mtr <= MemtoReg_i; m_alu <= ALUResult_i; m_rd <= RDaddr_i;
      m_mdata <= 32'h0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    logic exp_stall;
    forever begin
      @(negedge clk_i);
      exp_stall = m_active | (~m_active & ~m_ready & (MemRead_i | MemWrite_i));
      checkOutput("cyc_stall", 32'(stall_o), 32'(exp_stall));
      checkOutput("cyc_req", 32'(mem_req_o), 32'(m_req));
      checkOutput("cyc_we", 32'(mem_we_o), 32'(m_we));
      checkOutput("cyc_addr", mem_addr_o, m_addr);
      checkOutput("cyc_wdata", mem_wdata_o, m_wdata);
      checkOutput("cyc_err", 32'(err_o), 32'(m_err));
      checkOutput("cyc_regwrite", 32'(RegWrite_o), 32'(m_rw));
      checkOutput("cyc_memtoreg", 32'(MemtoReg_o), 32'(m_mtr));
      checkOutput("cyc_alu", ALUResult_o, m_alu);
      checkOutput("cyc_memdata", MemData_o, m_mdata);
      checkOutput("cyc_rd", 32'(RDaddr_o), 32'(m_rd));
    end
  end

  // Length of the most recent low stretch of mem_req_o before a new request.
  int   low_run = 0;
  int   last_gap = -1;
  logic prev_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (mem_req_o && !prev_req) last_gap = low_run;
      low_run  = mem_req_o ? 0 : low_run + 1;
      prev_req = mem_req_o;
    end
  end

  task automatic applyStimulus(input logic rw, input logic mtr, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    ALUResult_i = alu; RS2data_i = rs2; RDaddr_i = rd;
  endtask

  // Holds an instruction in EX/MEM until the stage accepts it; acks on the
  // ack_at-th request cycle (0 = never). Returns at posedge+1 after acceptance.
  task automatic runOp(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input int ack_at, input logic [31:0] rdata,
                       output int stall_cyc, output int busy_cyc, output logic we_seen,
                       output logic [31:0] addr_seen, output logic [31:0] wdata_seen);
    logic st;
    applyStimulus(rw, mtr, mr, mw, alu, rs2, rd);
    stall_cyc = 0; busy_cyc = 0; we_seen = 0; addr_seen = 0; wdata_seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i); #1;
      st = stall_o;
      if (st) stall_cyc++;
      if (mem_req_o) begin
        busy_cyc++;
        we_seen = mem_we_o; addr_seen = mem_addr_o; wdata_seen = mem_wdata_o;
        if (busy_cyc == ack_at) begin
          mem_ack_i = 1'b1; mem_rdata_i = rdata;
        end
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      if (!st) return;
    end
    checks++; errors++;
    $display("[TB] FAIL op_accept: stall still %0d after 64 cycles, required 0", stall_o);
  endtask

  int          sc, bc;
  logic        we;
  logic [31:0] ad, wd;

  initial begin
    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_stall", 32'(stall_o), 32'h0);
    checkOutput("rst_req", 32'(mem_req_o), 32'h0);
    checkOutput("rst_err", 32'(err_o), 32'h0);
    checkOutput("rst_regwrite", 32'(RegWrite_o), 32'h0);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] non-memory op");
    runOp(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, 0, 32'h0, sc, bc, we, ad, wd);
    checkOutput("t1_stall", 32'(sc), 32'd0);
    checkOutput("t1_req", 32'(bc), 32'd0);
    checkOutput("t1_regwrite", 32'(RegWrite_o), 32'h1);
    checkOutput("t1_alu", ALUResult_o, 32'h10);
    checkOutput("t1_rd", 32'(RDaddr_o), 32'd5);
    checkOutput("t1_memdata", MemData_o, 32'h0);

    $display("[TB] load, ack on third wait cycle");
    runOp(1, 1, 1, 0, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF, sc, bc, we, ad, wd);
    checkOutput("t2_stall", 32'(sc), 32'd4);
    checkOutput("t2_req", 32'(bc), 32'd3);
    checkOutput("t2_we", 32'(we), 32'h0);
    checkOutput("t2_addr", ad, 32'h100);
    checkOutput("t2_regwrite", 32'(RegWrite_o), 32'h1);
    checkOutput("t2_memtoreg", 32'(MemtoReg_o), 32'h1);
    checkOutput("t2_memdata", MemData_o, 32'hDEADBEEF);
    checkOutput("t2_rd", 32'(RDaddr_o), 32'd7);

    $display("[TB] store, ack on first wait cycle");
    runOp(0, 0, 0, 1, 32'h200, 32'hCAFEF00D, 5'd0, 1, 32'h77777777, sc, bc, we, ad, wd);
    checkOutput("t3_stall", 32'(sc), 32'd2);
    checkOutput("t3_we", 32'(we), 32'h1);
    checkOutput("t3_addr", ad, 32'h200);
    checkOutput("t3_wdata", wd, 32'hCAFEF00D);
    checkOutput("t3_regwrite", 32'(RegWrite_o), 32'h0);
    checkOutput("t3_memdata", MemData_o, 32'h0);

    $display("[TB] load timeout");
    runOp(1, 1, 1, 0, 32'h180, 32'h0, 5'd9, 0, 32'h0, sc, bc, we, ad, wd);
    checkOutput("t4_req", 32'(bc), 32'd4);
    checkOutput("t4_stall", 32'(sc), 32'd5);
    checkOutput("t4_err", 32'(err_o), 32'h1);
    checkOutput("t4_memdata", MemData_o, 32'h0);
    checkOutput("t4_rd", 32'(RDaddr_o), 32'd9);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    @(posedge clk_i); #1;
    checkOutput("t4_late_err", 32'(err_o), 32'h1);
    checkOutput("t4_late_req", 32'(mem_req_o), 32'h0);
    checkOutput("t4_late_memdata", MemData_o, 32'h0);

    $display("[TB] reset during wait");
    applyStimulus(1, 1, 1, 0, 32'h280, 32'h0, 5'd4);
    @(negedge clk_i); @(negedge clk_i); #2;
    checkOutput("t5_busy_req", 32'(mem_req_o), 32'h1);
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    #1;
    checkOutput("t5_rst_req", 32'(mem_req_o), 32'h0);
    checkOutput("t5_rst_stall", 32'(stall_o), 32'h0);
    checkOutput("t5_rst_err", 32'(err_o), 32'h0);
    checkOutput("t5_rst_addr", mem_addr_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    checkOutput("t5_stray_req", 32'(mem_req_o), 32'h0);
    checkOutput("t5_stray_stall", 32'(stall_o), 32'h0);
    checkOutput("t5_stray_memdata", MemData_o, 32'h0);
    runOp(1, 1, 1, 0, 32'h300, 32'h0, 5'd12, 2, 32'h12345678, sc, bc, we, ad, wd);
    checkOutput("t5_stall", 32'(sc), 32'd3);
    checkOutput("t5_addr", ad, 32'h300);
    checkOutput("t5_memdata", MemData_o, 32'h12345678);
    checkOutput("t5_rd", 32'(RDaddr_o), 32'd12);

    $display("[TB] back-to-back load and store, then dual-flag op");
    runOp(1, 1, 1, 0, 32'h400, 32'h0, 5'd3, 1, 32'h0BADF00D, sc, bc, we, ad, wd);
    checkOutput("t6_ld_memdata", MemData_o, 32'h0BADF00D);
    checkOutput("t6_ld_rd", 32'(RDaddr_o), 32'd3);
    runOp(0, 0, 0, 1, 32'h404, 32'h55AA55AA, 5'd0, 2, 32'h99999999, sc, bc, we, ad, wd);
    checkOutput("t6_gap", 32'(last_gap), 32'd2);
    checkOutput("t6_st_we", 32'(we), 32'h1);
    checkOutput("t6_st_wdata", wd, 32'h55AA55AA);
    checkOutput("t6_st_stall", 32'(sc), 32'd3);
    runOp(1, 1, 1, 1, 32'h408, 32'h11112222, 5'd6, 1, 32'hFFFFFFFF, sc, bc, we, ad, wd);
    checkOutput("t6_dual_we", 32'(we), 32'h1);
    checkOutput("t6_dual_wdata", wd, 32'h11112222);
    checkOutput("t6_dual_stall", 32'(sc), 32'd2);
    checkOutput("t6_dual_memdata", MemData_o, 32'h0);
    checkOutput("t6_dual_rd", 32'(RDaddr_o), 32'd6);

    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 5'h0);
    repeat (3) @(posedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
